// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core.
// One Feistel round per clock through a single round datapath. The key
// schedule starts from C0/D0 (which equals C16/D16) and right-rotates toward
// C1/D1. Vector ports use [64:1] with bit 64 carrying FIPS bit 1, so FIPS
// bit i of an N-bit vector sits at index N+1-i.
module des_decrypt_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [64:1] key,
  input  logic [64:1] din,
  output logic [64:1] dout,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Permutation tables, FIPS 1-based source positions
  localparam logic [6:0] IP_T [0:63] = '{
    7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,  7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
    7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,  7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
    7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,  7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
  };

  localparam logic [6:0] FP_T [0:63] = '{
    7'd40, 7'd8,  7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32, 7'd39, 7'd7,  7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
    7'd38, 7'd6,  7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30, 7'd37, 7'd5,  7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
    7'd36, 7'd4,  7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28, 7'd35, 7'd3,  7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
    7'd34, 7'd2,  7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26, 7'd33, 7'd1,  7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
  };

  localparam logic [6:0] PC1_T [0:55] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  localparam logic [5:0] PC2_T [0:47] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  localparam logic [5:0] E_T [0:47] = '{
    6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,  6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
    6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
    6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
    6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29, 6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1
  };

  localparam logic [5:0] P_T [0:31] = '{
    6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17, 6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
    6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,  6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
  };

  // S-boxes: 64 nibbles each, entry 0 in the most significant nibble,
  // entry index = row*16 + column
  localparam logic [255:0] SBOX [0:7] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [64:1] perm_ip(input logic [64:1] x);
    logic [64:1] y;
    y = 64'd0;
    for (int j = 0; j < 64; j++) begin
      y[7'(64 - j)] = x[7'd65 - IP_T[6'(j)]];
    end
    return y;
  endfunction

  function automatic logic [64:1] perm_fp(input logic [64:1] x);
    logic [64:1] y;
    y = 64'd0;
    for (int j = 0; j < 64; j++) begin
      y[7'(64 - j)] = x[7'd65 - FP_T[6'(j)]];
    end
    return y;
  endfunction

  function automatic logic [56:1] perm_pc1(input logic [64:1] x);
    logic [56:1] y;
    y = 56'd0;
    for (int j = 0; j < 56; j++) begin
      y[6'(56 - j)] = x[7'd65 - PC1_T[6'(j)]];
    end
    return y;
  endfunction

  function automatic logic [48:1] perm_pc2(input logic [56:1] x);
    logic [48:1] y;
    y = 48'd0;
    for (int j = 0; j < 48; j++) begin
      y[6'(48 - j)] = x[6'd57 - PC2_T[6'(j)]];
    end
    return y;
  endfunction

  function automatic logic [48:1] expand(input logic [32:1] x);
    logic [48:1] y;
    y = 48'd0;
    for (int j = 0; j < 48; j++) begin
      y[6'(48 - j)] = x[6'd33 - E_T[6'(j)]];
    end
    return y;
  endfunction

  function automatic logic [32:1] perm_p(input logic [32:1] x);
    logic [32:1] y;
    y = 32'd0;
    for (int j = 0; j < 32; j++) begin
      y[6'(32 - j)] = x[6'd33 - P_T[5'(j)]];
    end
    return y;
  endfunction

  // Outer bits select the row, inner four bits the column
  function automatic logic [3:0] sbox_lookup(input logic [255:0] tbl, input logic [5:0] six);
    logic [5:0] idx;
    logic [7:0] pos;
    idx = {six[5], six[0], six[4:1]};
    pos = 8'd255 - {idx, 2'b00};
    return tbl[pos -: 4];
  endfunction

  function automatic logic [32:1] feistel(input logic [32:1] r, input logic [48:1] k);
    logic [48:1] x;
    logic [32:1] s;
    x = expand(r) ^ k;
    s = 32'd0;
    for (int b = 0; b < 8; b++) begin
      s[6'(32 - 4 * b) -: 4] = sbox_lookup(SBOX[3'(b)], x[6'(48 - 6 * b) -: 6]);
    end
    return perm_p(s);
  endfunction

  // Right rotation in FIPS order moves FIPS bit 28 (index 1) to FIPS bit 1
  function automatic logic [28:1] rotr28(input logic [28:1] x, input logic [1:0] amt);
    logic [28:1] y;
    case (amt)
      2'd1:    y = {x[1], x[28:2]};
      2'd2:    y = {x[2:1], x[28:3]};
      default: y = x;
    endcase
    return y;
  endfunction

  state_t      state_r, state_nx_s;
  logic        busy_nx_s, done_nx_s;
  logic [32:1] l_r, r_r;
  logic [28:1] c_r, d_r;
  logic [4:0]  cnt_r;
  logic [1:0]  rot_s;
  logic [28:1] c_rot_s, d_rot_s;
  logic [48:1] subkey_s;
  logic [32:1] l_nx_s, r_nx_s;
  logic [64:1] plain_s;

  // Control FSM next state plus the busy/done values to register with it.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = LOAD;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOAD: state_nx_s = RUN;
      RUN: begin
        if (cnt_r == 5'd16) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
    busy_nx_s = (state_nx_s == LOAD) || (state_nx_s == RUN);
    done_nx_s = (state_nx_s == DONE);
  end

  // Single round datapath: key schedule step, f-function and final permutation.
  always_comb begin
    rot_s = 2'd0;
    case (cnt_r)
      5'd1:                                       rot_s = 2'd0;
      5'd2, 5'd9, 5'd16:                          rot_s = 2'd1;
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
      5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15:   rot_s = 2'd2;
      default:                                    rot_s = 2'd0;
    endcase
    c_rot_s  = rotr28(c_r, rot_s);
    d_rot_s  = rotr28(d_r, rot_s);
    subkey_s = perm_pc2({c_rot_s, d_rot_s});
    l_nx_s   = r_r;
    r_nx_s   = l_r ^ feistel(r_r, subkey_s);
    plain_s  = perm_fp({r_nx_s, l_nx_s});
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy    <= busy_nx_s;
      done    <= done_nx_s;
    end
  end

  // Block state: capture in LOAD, one round per RUN edge, result on round 16.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_r   <= 32'd0;
      r_r   <= 32'd0;
      c_r   <= 28'd0;
      d_r   <= 28'd0;
      cnt_r <= 5'd0;
      dout  <= 64'd0;
    end else begin
      case (state_r)
        LOAD: begin
          {l_r, r_r} <= perm_ip(din);
          {c_r, d_r} <= perm_pc1(key);
          cnt_r      <= 5'd1;
        end
        RUN: begin
          l_r <= l_nx_s;
          r_r <= r_nx_s;
          c_r <= c_rot_s;
          d_r <= d_rot_s;
          if (cnt_r == 5'd16) begin
            dout <= plain_s;
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Self-checking bench for des_decrypt_iter: directed known-answer vectors,
// control corner cases, and a round trip against an encryption model.
module tb_des_decrypt_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [64:1] key;
  logic [64:1] din;
  logic [64:1] dout;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  des_decrypt_iter dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .key   (key),
    .din   (din),
    .dout  (dout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference tables (FIPS 46-3), 1-based source positions
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                               64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18, 10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15,7,62,54,46,38,30,22, 14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10, 23,19,12,4,26,8,16,7,27,20,13,2,
                                41,52,31,37,47,55,30,40,51,45,33,48, 44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int S_T [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  function automatic int tab(input int sel, input int j);
    case (sel)
      0:       return IP_T[j];
      1:       return PC1_T[j];
      2:       return PC2_T[j];
      3:       return E_T[j];
      default: return P_T[j];
    endcase
  endfunction

  // FIPS bit pos (1 = MSB) of a right-aligned w-bit value
  function automatic logic [63:0] getbit(input logic [63:0] x, input int w, input int pos);
    return (x >> (w - pos)) & 64'd1;
  endfunction

  function automatic logic [63:0] perm(input logic [63:0] x, input int w, input int sel, input int n);
    logic [63:0] y;
    y = 64'd0;
    for (int j = 0; j < n; j++) y = (y << 1) | getbit(x, w, tab(sel, j));
    return y;
  endfunction

  // Final permutation taken as the inverse of IP
  function automatic logic [63:0] inv_ip(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int j = 0; j < 64; j++) begin
      if (getbit(x, 64, j + 1) != 64'd0) y = y | (64'd1 << (64 - IP_T[j]));
    end
    return y;
  endfunction

  function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
    logic [63:0] x, o;
    logic [5:0]  six;
    logic [31:0] s;
    x = perm({32'd0, r}, 32, 3, 48) ^ {16'd0, k};
    s = 32'd0;
    for (int b = 0; b < 8; b++) begin
      six = 6'((x >> (42 - 6 * b)) & 64'h3f);
      s = (s << 4) | S_T[b][{six[5], six[0], six[4:1]}];
    end
    o = perm({32'd0, s}, 32, 4, 32);
    return o[31:0];
  endfunction

  function automatic logic [63:0] des_enc(input logic [63:0] k, input logic [63:0] p);
    logic [63:0] cd, ipv, sub;
    logic [27:0] c, d;
    logic [31:0] l, r, t;
    cd  = perm(k, 64, 1, 56);
    c   = cd[55:28];
    d   = cd[27:0];
    ipv = perm(p, 64, 0, 64);
    l   = ipv[63:32];
    r   = ipv[31:0];
    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < SHIFT_T[n]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      sub = perm({8'd0, c, d}, 56, 2, 48);
      t = r;
      r = l ^ f_model(r, sub[47:0]);
      l = t;
    end
    return inv_ip({r, l});
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one block and watch a 22-cycle window after the start edge
  task automatic run_block(input logic [63:0] k, input logic [63:0] c, input bit scramble,
                           output logic [63:0] res, output int lat, output int busy_n, output int done_n);
    key   = k;
    din   = c;
    start = 1'b1;
    tick();
    start  = 1'b0;
    res    = 64'd0;
    lat    = -1;
    busy_n = 0;
    done_n = 0;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat < 0) begin
          lat = cyc;
          res = dout;
        end
      end
      if (scramble && cyc >= 2) begin
        key = {$urandom, $urandom};
        din = {$urandom, $urandom};
      end
      tick();
    end
  endtask

  typedef struct {
    logic [63:0] key;
    logic [63:0] ct;
    logic [63:0] pt;
  } vec_t;

  vec_t        vecs [8];
  logic [63:0] res, r1, r2, k, p;
  int          lat, busy_n, done_n, t1, t2;

  initial begin
    vecs[0] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF};
    vecs[1] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787};
    vecs[2] = '{64'h0000000000000000, 64'h8CA64DE9C1B123A7, 64'h0000000000000000};
    vecs[3] = '{64'h0101010101010101, 64'h8CA64DE9C1B123A7, 64'h0000000000000000};
    vecs[4] = '{64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF};
    vecs[5] = '{64'hFEFEFEFEFEFEFEFE, 64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF};
    vecs[6] = '{64'h3000000000000000, 64'h958E6E627A05557B, 64'h1000000000000001};
    vecs[7] = '{64'h1111111111111111, 64'hF40379AB9E0EC533, 64'h1111111111111111};

    rst   = 1'b1;
    start = 1'b0;
    key   = 64'd0;
    din   = 64'd0;
    tick();
    tick();
    check("reset_dout", dout, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);

    // rst wins over start on the same edge
    start = 1'b1;
    tick();
    check("rst_start_busy", 64'(busy), 64'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("rst_start_idle", 64'(busy), 64'd0);

    // Known-answer table
    foreach (vecs[i]) begin
      run_block(vecs[i].key, vecs[i].ct, 1'b0, res, lat, busy_n, done_n);
      check($sformatf("vec%0d_dout", i), res, vecs[i].pt);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd18);
      check($sformatf("vec%0d_busy_cycles", i), 64'(busy_n), 64'd17);
      check($sformatf("vec%0d_done_count", i), 64'(done_n), 64'd1);
    end

    // Second start during round 8 with a different din is ignored
    key   = vecs[0].key;
    din   = vecs[0].ct;
    start = 1'b1;
    tick();
    start  = 1'b0;
    done_n = 0;
    lat    = -1;
    res    = 64'd0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (done) begin
        done_n++;
        if (lat < 0) begin
          lat = cyc;
          res = dout;
        end
      end
      start = (cyc == 9);
      if (cyc == 9) din = 64'hFFFFFFFFFFFFFFFF;
      tick();
    end
    check("ignore_start_done_count", 64'(done_n), 64'd1);
    check("ignore_start_latency", 64'(lat), 64'd18);
    check("ignore_start_dout", res, vecs[0].pt);

    // start held high: back-to-back blocks 19 cycles apart
    key   = vecs[0].key;
    din   = vecs[0].ct;
    start = 1'b1;
    t1 = -1;
    t2 = -1;
    r1 = 64'd0;
    r2 = 64'd0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      tick();
      if (done) begin
        if (t1 < 0) begin
          t1 = cyc;
          r1 = dout;
        end else if (t2 < 0) begin
          t2 = cyc;
          r2 = dout;
        end
      end
    end
    start = 1'b0;
    repeat (30) tick();
    check("held_first_latency", 64'(t1), 64'd18);
    check("held_spacing", 64'(t2 - t1), 64'd19);
    check("held_dout1", r1, vecs[0].pt);
    check("held_dout2", r2, vecs[0].pt);

    // Reset during round 10 aborts the block
    key   = vecs[1].key;
    din   = vecs[1].ct;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset_dout", dout, 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    done_n = 0;
    busy_n = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (done) done_n++;
      if (busy) busy_n++;
      tick();
    end
    check("midreset_no_done", 64'(done_n), 64'd0);
    check("midreset_stays_idle", 64'(busy_n), 64'd0);
    run_block(vecs[1].key, vecs[1].ct, 1'b0, res, lat, busy_n, done_n);
    check("after_reset_dout", res, vecs[1].pt);
    check("after_reset_latency", 64'(lat), 64'd18);

    // key/din scrambled every cycle after LOAD
    run_block(vecs[0].key, vecs[0].ct, 1'b1, res, lat, busy_n, done_n);
    check("scramble_dout", res, vecs[0].pt);
    check("scramble_done_count", 64'(done_n), 64'd1);

    // Round trip through the encryption model
    for (int n = 0; n < 1000; n++) begin
      k = {$urandom, $urandom};
      p = {$urandom, $urandom};
      run_block(k, des_enc(k, p), 1'b0, res, lat, busy_n, done_n);
      check($sformatf("roundtrip%0d key=%h", n, k), res, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_decrypt_iter.md
DES_DECRYPT_ITER -- requirements
Module: des_decrypt_iter

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have rst, input, 1, reset that is synchronous and active-high.
REQ-003 SHALL have start, input, 1, request to decrypt din with key; sampled only in IDLE.
REQ-004 SHALL have key, input, [64:1], DES key; bit 64 = FIPS bit 1; parity bits ignored.
REQ-005 SHALL have din, input, [64:1], ciphertext block; bit 64 = FIPS bit 1.
REQ-006 SHALL have dout, output, [64:1], recovered plaintext; registered.
REQ-007 SHALL have busy, output, 1, high while a block is in progress (LOAD or RUN).
REQ-008 SHALL have done, output, 1, one-cycle pulse marking dout valid.

Function
REQ-009 SHALL implement FIPS 46-3 DES decryption: IP, then 16 Feistel rounds with subkeys K16..K1, then swap and FP.
REQ-010 SHALL iterate one round per clock using a single round datapath: E expansion, XOR with subkey, S1..S8, P permutation, XOR with L.
REQ-011 SHALL contain FSM states IDLE, LOAD, RUN, DONE; reset state IDLE.
REQ-012 SHALL move IDLE->LOAD on a clock edge where start=1; start=0 keeps IDLE.
REQ-013 SHALL, in LOAD, register L/R = IP(din) and C/D = PC-1(key), clear round counter to 1, and go to RUN.
REQ-014 SHALL, on each RUN edge, set L<=R, R<=L xor f(R,Kn), increment the counter, and leave RUN after round 16.
REQ-015 SHALL derive the round-1 subkey as PC-2(C,D) with C/D unrotated, since C0D0 equals C16D16.
REQ-016 SHALL right-rotate C and D before rounds 2..16 by 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 bits respectively.
REQ-017 SHALL, on leaving RUN, register dout = FP({R16,L16}) and enter DONE.
REQ-018 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-019 SHALL give a latency of 18 cycles, measured from the edge that samples start to the first cycle in which done=1.
REQ-020 SHALL keep dout stable from DONE until the next DONE; dout SHALL NOT change during LOAD or RUN.
REQ-021 SHALL ignore start while in LOAD, RUN or DONE; no queuing.
REQ-022 SHALL capture key and din only in LOAD; changes to them afterwards SHALL NOT affect the block in progress.
REQ-023 SHALL drive busy=1 in LOAD and RUN and busy=0 in IDLE and DONE.
REQ-024 SHALL size the round counter at 5 bits; it SHALL never wrap past 16.

Reset
REQ-025 SHALL, when rst=1 at an edge, force state IDLE and set dout=0, busy=0, done=0, L=R=0, C=D=0, counter=0.
REQ-026 SHALL give rst priority over start, including when rst and start are both high on the same edge.
REQ-027 SHALL, on reset mid-operation (LOAD, RUN or DONE), abort the block with no done pulse and need a new start afterwards.

Verification
REQ-028 SHALL pass this vector: key 133457799BBCDFF1, din 85E813540F0AB405, start pulse -> done 18 cycles later, dout 0123456789ABCDEF.
REQ-029 SHALL pass this vector: key 0E329232EA6D0D73, din 0000000000000000 -> dout 8787878787878787, done a single cycle, busy high for 17 cycles.
REQ-030 SHALL be checked for start ignored while busy: second start in round 8 with a different din -> only one done, first result unaffected; start then held high -> back-to-back blocks spaced 19 cycles apart.
REQ-031 SHALL be checked for reset mid-block: rst asserted in round 10 -> next cycle dout=0, busy=0, no done; new start -> correct result.
REQ-032 SHALL be checked for input stability: din and key changed every cycle after LOAD -> dout still matches the vector captured in LOAD.
REQ-033 SHALL be checked by round trip: 1000 random key/plaintext pairs encrypted by the reference model, then decrypted by the DUT -> dout equals the original plaintext.
